// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage multiply/divide unit.
// Holds the MDU op encoding, its FSM state type and the multiDiv function-code field.
// Pure declarations; no logic, no latency, no flow control.
package cpu_pkg;

  // MDU operation select
  localparam logic MDU_OP_MUL = 1'b0;
  localparam logic MDU_OP_DIV = 1'b1;

  // Function-code field that identifies the multiDiv instruction class
  localparam int FUNC_MULDIV_MSB = 3;
  localparam int FUNC_MULDIV_LSB = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/mul_div_unit.sv
// Iterative signed multiply/divide: one bit per cycle on magnitudes, sign fixed up at the end.
// Latency: done WIDTH+2 cycles after an accepted start (1 cycle for divide-by-zero).
// Backpressure: stall holds the upstream pipeline from the start cycle through FIX; starts while busy are ignored.
module mul_div_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic             kill,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             div_by_zero
);
  import cpu_pkg::*;

  mdu_state_t         state;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;
  logic               res_neg;   // product / quotient sign
  logic               a_neg;     // dividend sign, used for the remainder
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH-1:0]   shreg;     // MUL: multiplier shifting out; DIV: dividend out, quotient in
  logic [2*WIDTH-1:0] acc;       // MUL product accumulator
  logic [WIDTH:0]     rem;       // DIV partial remainder

  // Magnitudes; -2^(WIDTH-1) maps to 2^(WIDTH-1) when read as unsigned
  logic [WIDTH-1:0] op_a_mag, op_b_mag;
  assign op_a_mag = op_a[WIDTH-1] ? -op_a : op_a;
  assign op_b_mag = op_b[WIDTH-1] ? -op_b : op_b;

  // One shift-add step: add multiplicand into the top half, then shift the whole product right
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (shreg[0] ? {1'b0, mag_a} : '0);

  // One restoring-division step: bring in next dividend bit, subtract if it fits
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ge;
  assign div_shift = {rem[WIDTH-1:0], shreg[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
  assign div_ge    = ~div_diff[WIDTH+1];

  // Sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  assign prod_fix = res_neg ? -acc : acc;
  assign quo_fix  = res_neg ? -shreg : shreg;
  assign rem_fix  = a_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  assign stall = (state == IDLE && start) || state == CALC || state == FIX;
  assign busy  = state != IDLE;

  // Control FSM and iterative datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= MDU_OP_MUL;
      res_neg     <= 1'b0;
      a_neg       <= 1'b0;
      mag_a       <= '0;
      mag_b       <= '0;
      shreg       <= '0;
      acc         <= '0;
      rem         <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op_q        <= op;
              cnt         <= '0;
              div_by_zero <= 1'b0;
              if (op == MDU_OP_DIV && op_b == '0) begin
                result_lo   <= '1;
                result_hi   <= op_a;
                div_by_zero <= 1'b1;
                done        <= 1'b1;
                state       <= DONE;
              end else begin
                mag_a   <= op_a_mag;
                mag_b   <= op_b_mag;
                res_neg <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                a_neg   <= op_a[WIDTH-1];
                acc     <= '0;
                rem     <= '0;
                shreg   <= (op == MDU_OP_DIV) ? op_a_mag : op_b_mag;
                state   <= CALC;
              end
            end
          end
          CALC: begin
            if (op_q == MDU_OP_MUL) begin
              acc   <= {mul_sum, acc[WIDTH-1:1]};
              shreg <= shreg >> 1;
            end else begin
              rem   <= div_ge ? div_diff[WIDTH:0] : div_shift;
              shreg <= {shreg[WIDTH-2:0], div_ge};
            end
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state <= FIX;
            end
          end
          FIX: begin
            if (op_q == MDU_OP_MUL) begin
              result_lo <= prod_fix[WIDTH-1:0];
              result_hi <= prod_fix[2*WIDTH-1:WIDTH];
            end else begin
              result_lo <= quo_fix;
              result_hi <= rem_fix;
            end
            cnt   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: driver pushes model results, monitor checks each done pulse.
// Reference results come from plain signed integer arithmetic.
// Covers directed corner cases, kill, mid-operation reset, ignored start and random operations.
module tb_mul_div_unit;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        op;
  logic        kill;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        stall;
  logic        busy;
  logic        done;
  logic [15:0] result_lo;
  logic [15:0] result_hi;
  logic        div_by_zero;

  mul_div_unit #(.WIDTH(16), .CNT_W(5)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .op          (op),
    .kill        (kill),
    .op_a        (op_a),
    .op_b        (op_b),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .result_lo   (result_lo),
    .result_hi   (result_hi),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic        dbz;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [15:0] last_lo = '0;
  logic [15:0] last_hi = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: signed arithmetic with truncating division
  function automatic exp_t model(input bit o, input logic [15:0] a, input logic [15:0] b, input int c);
    exp_t   e;
    int     sa;
    int     sb;
    int     q;
    int     r;
    longint p;
    sa = $signed(a);
    sb = $signed(b);
    if (o == 1'b0) begin
      p     = longint'(sa) * longint'(sb);
      e.lo  = p[15:0];
      e.hi  = p[31:16];
      e.dbz = 1'b0;
      e.cyc = c + 18;
    end else if (sb == 0) begin
      e.lo  = 16'hFFFF;
      e.hi  = a;
      e.dbz = 1'b1;
      e.cyc = c + 1;
    end else begin
      q     = sa / sb;
      r     = sa % sb;
      e.lo  = q[15:0];
      e.hi  = r[15:0];
      e.dbz = 1'b0;
      e.cyc = c + 18;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (reset_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: done=1 at cycle %0d, expected no done", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("result_lo", {16'h0, result_lo}, {16'h0, mon_e.lo});
          check("result_hi", {16'h0, result_hi}, {16'h0, mon_e.hi});
          check("div_by_zero", {31'h0, div_by_zero}, {31'h0, mon_e.dbz});
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
        mon_e = exp_q.pop_front();
        n_cmp++;
        n_fail++;
        $display("FAIL missing_done: no done by cycle %0d, expected at cycle %0d", cyc, mon_e.cyc);
      end
    end
  end

  task automatic issue(input bit o, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    @(negedge clk);
    op    = o;
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    e = model(o, a, b, cyc);
    exp_q.push_back(e);
    last_lo = e.lo;
    last_hi = e.hi;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #2;
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d, expected idle with nothing pending", busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'h7FFF;
      4: return 16'(int'($urandom_range(0, 20)) - 10);
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n0;
    reset_n = 1'b0;
    start   = 1'b0;
    op      = 1'b0;
    kill    = 1'b0;
    op_a    = '0;
    op_b    = '0;
    repeat (3) @(negedge clk);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_stall", {31'h0, stall}, 32'h0);
    check("rst_result", {result_hi, result_lo}, 32'h0);
    check("rst_dbz", {31'h0, div_by_zero}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // 7 * -3 with stall profile
    @(negedge clk);
    op = 1'b0; op_a = 16'h0007; op_b = 16'hFFFD; start = 1'b1;
    n0 = cyc;
    exp_q.push_back(model(1'b0, 16'h0007, 16'hFFFD, n0));
    #1 check("stall_start", {31'h0, stall}, 32'h1);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      start = 1'b0;
      #1 check("stall_iter", {31'h0, stall}, 32'h1);
    end
    @(negedge clk);
    #1 check("stall_done", {31'h0, stall}, 32'h0);
    check("busy_done", {31'h0, busy}, 32'h1);
    wait_idle();

    // Directed corners
    issue(1'b0, 16'h8000, 16'h8000); wait_idle();
    issue(1'b1, 16'd100, 16'hFFF9);  wait_idle();
    issue(1'b1, 16'hFF9C, 16'd7);    wait_idle();
    issue(1'b1, 16'd5, 16'h0000);    wait_idle();
    issue(1'b1, 16'h8000, 16'hFFFF); wait_idle();
    check("hold_lo", {16'h0, result_lo}, {16'h0, last_lo});
    check("hold_hi", {16'h0, result_hi}, {16'h0, last_hi});

    // Kill during CALC: no done, results unchanged
    @(negedge clk);
    op = 1'b0; op_a = 16'h0123; op_b = 16'h0045; start = 1'b1;
    n0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n0 + 5) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    #2 check("kill_idle", {31'h0, busy}, 32'h0);
    repeat (20) @(negedge clk);
    check("kill_lo", {16'h0, result_lo}, {16'h0, last_lo});
    check("kill_hi", {16'h0, result_hi}, {16'h0, last_hi});

    // Reset mid-divide, then a fresh operation
    @(negedge clk);
    op = 1'b1; op_a = 16'h1234; op_b = 16'h0011; start = 1'b1;
    n0 = cyc;
    @(negedge clk);
    start = 1'b0;
    while (cyc < n0 + 9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    check("mid_rst_result", {result_hi, result_lo}, 32'h0);
    check("mid_rst_dbz", {31'h0, div_by_zero}, 32'h0);
    check("mid_rst_stall", {31'h0, stall}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(1'b1, 16'h1234, 16'h0011); wait_idle();

    // Second start during CALC is ignored
    @(negedge clk);
    op = 1'b0; op_a = 16'd1234; op_b = 16'hFFFB; start = 1'b1;
    exp_q.push_back(model(1'b0, 16'd1234, 16'hFFFB, cyc));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op = 1'b1; op_a = 16'h0042; op_b = 16'h0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Random operations
    for (int i = 0; i < 60; i++) begin
      issue(1'($urandom_range(0, 1)), pick_operand(), pick_operand());
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
